// File: rtl/fft_sample_loader.sv
// Packs a valid/ready stream of complex samples into {re,im} words and writes one frame into the FFT RAM.
// Define FFT_LOADER_BITREV_EN to store the frame in bit-reversed address order; natural order otherwise.
`timescale 1ns/1ps
module fft_sample_loader #(
  parameter int ADDR_W = 10,
  parameter int SAMP_W = 16,
  parameter int RAM_AW = 16
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                arm_i,
  input  logic                fft_busy_i,
  input  logic                s_valid_i,
  output logic                s_ready_o,
  input  logic [SAMP_W-1:0]   s_re_i,
  input  logic [SAMP_W-1:0]   s_im_i,
  output logic                we_o,
  output logic [RAM_AW-1:0]   addr_o,
  output logic [2*SAMP_W-1:0] data_o,
  output logic                busy_o,
  output logic                frame_done_o,
  output logic [15:0]         drop_cnt_o,
  output logic [1:0]          state_dbg
);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    CAPTURE = 2'd1,
    DONE    = 2'd2
  } state_t;

  state_t            state;
  logic [ADDR_W-1:0] count;
  logic [ADDR_W-1:0] map_addr;
  logic              accept;
  logic              last;

  // A sample transfers on any rising edge where s_valid_i && s_ready_o; the source must hold its
  // data while valid is high and not accepted. Ready drops whenever the FFT engine owns the RAM.
  assign s_ready_o = (state == CAPTURE) && !fft_busy_i;
  assign accept    = s_valid_i && s_ready_o;
  assign last      = (count == {ADDR_W{1'b1}});
  assign busy_o    = (state != IDLE);
  assign state_dbg = state;

`ifdef FFT_LOADER_BITREV_EN
  always_comb begin
    map_addr = '0;
    for (int i = 0; i < ADDR_W; i++) map_addr[i] = count[ADDR_W-1-i];
  end
`else
  assign map_addr = count;
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state        <= IDLE;
      count        <= '0;
      we_o         <= 1'b0;
      addr_o       <= '0;
      data_o       <= '0;
      frame_done_o <= 1'b0;
      drop_cnt_o   <= '0;
    end else begin
      // The write issued here lands one cycle after its accept, even if fft_busy_i has since risen.
      we_o         <= accept;
      frame_done_o <= accept && last;
      if (accept) begin
        addr_o <= {{(RAM_AW-ADDR_W){1'b0}}, map_addr};
        data_o <= {s_re_i, s_im_i};
      end
      if (s_valid_i && !s_ready_o && (drop_cnt_o != 16'hFFFF))
        drop_cnt_o <= drop_cnt_o + 16'd1;
      case (state)
        IDLE: begin
          if (arm_i && !fft_busy_i) begin
            state <= CAPTURE;
            count <= '0;
          end
        end
        CAPTURE: begin
          if (accept) begin
            if (last) state <= DONE;
            else      count <= count + {{(ADDR_W-1){1'b0}}, 1'b1};
          end
        end
        DONE:    state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_fft_sample_loader.sv
// Bench for fft_sample_loader: directed frames with a posedge reference model feeding an expected-write
// queue that a negedge monitor drains and compares against the RAM write port.
`timescale 1ns/1ps
module tb_fft_sample_loader;
  localparam int ADDR_W = 10;
  localparam int SAMP_W = 16;
  localparam int RAM_AW = 16;
  localparam int DEPTH  = 1 << ADDR_W;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        arm = 1'b0;
  logic        fft_busy = 1'b0;
  logic        s_valid = 1'b0;
  logic [15:0] s_re = '0;
  logic [15:0] s_im = '0;
  logic        s_ready;
  logic        we;
  logic [15:0] addr;
  logic [31:0] data;
  logic        busy;
  logic        frame_done;
  logic [15:0] drop_cnt;
  logic [1:0]  state_dbg;

  int n_cmp = 0;
  int n_err = 0;
  logic [48:0] exp_q[$];

  int          m_state = 0;
  int          m_count = 0;
  logic [15:0] m_drop  = '0;
  int          writes_in_frame = 0;
  int          frames_done = 0;
  logic        chk_busy_next = 1'b0;
  logic [15:0] addr_k1    = 16'hFFFF;
  logic [15:0] addr_k3    = 16'hFFFF;
  logic [15:0] addr_k1023 = 16'hFFFF;

  always #5 clk = ~clk;

  fft_sample_loader #(.ADDR_W(ADDR_W), .SAMP_W(SAMP_W), .RAM_AW(RAM_AW)) dut (
    .clk(clk), .rst(rst), .arm_i(arm), .fft_busy_i(fft_busy),
    .s_valid_i(s_valid), .s_ready_o(s_ready), .s_re_i(s_re), .s_im_i(s_im),
    .we_o(we), .addr_o(addr), .data_o(data), .busy_o(busy),
    .frame_done_o(frame_done), .drop_cnt_o(drop_cnt), .state_dbg(state_dbg)
  );

  function automatic logic [15:0] map_addr(input int c);
    logic [15:0] a;
    a = '0;
`ifdef FFT_LOADER_BITREV_EN
    for (int i = 0; i < ADDR_W; i++)
      if ((c & (1 << i)) != 0) a = a | (16'h0200 >> i);
`else
    a = 16'(c);
`endif
    return a;
  endfunction

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: sees the same inputs as the DUT at each rising edge.
  always @(posedge clk) begin
    logic rdy;
    if (rst) begin
      m_state = 0;
      m_count = 0;
      m_drop  = '0;
    end else begin
      rdy = (m_state == 1) && !fft_busy;
      if (s_valid && !rdy && m_drop != 16'hFFFF) m_drop++;
      case (m_state)
        0: if (arm && !fft_busy) begin m_state = 1; m_count = 0; end
        1: if (s_valid && rdy) begin
             exp_q.push_back({m_count == DEPTH-1, map_addr(m_count), s_re, s_im});
             if (m_count == DEPTH-1) m_state = 2;
             else m_count++;
           end
        default: m_state = 0;
      endcase
    end
  end

  // Monitor: every write must match the head of the queue, and every queued write must appear.
  always @(negedge clk) begin
    logic [48:0] e;
    if (rst) begin
      check("reset_ctrl", {we, frame_done, busy, s_ready, state_dbg, drop_cnt}, '0);
      check("reset_bus", {addr, data}, '0);
      exp_q.delete();
      writes_in_frame = 0;
      chk_busy_next = 1'b0;
    end else begin
      check("ready", s_ready, (m_state == 1) && !fft_busy);
      check("busy", busy, m_state != 0);
      check("drop_cnt", drop_cnt, m_drop);
      if (chk_busy_next) begin
        check("busy_after_done", busy, 0);
        chk_busy_next = 1'b0;
      end
      if (we) begin
        if (exp_q.size() == 0) begin
          n_cmp++;
          n_err++;
          $display("FAIL unexpected_write: addr %0h data %0h at %0t", addr, data, $time);
        end else begin
          e = exp_q.pop_front();
          check("write_addr", addr, e[47:32]);
          check("write_data", data, e[31:0]);
          check("frame_done", frame_done, e[48]);
        end
        writes_in_frame++;
        if (data[31:16] == 16'd1)    addr_k1 = addr;
        if (data[31:16] == 16'd3)    addr_k3 = addr;
        if (data[31:16] == 16'd1023) addr_k1023 = addr;
        if (frame_done) begin
          check("frame_writes", writes_in_frame, DEPTH);
          writes_in_frame = 0;
          frames_done++;
          chk_busy_next = 1'b1;
        end
      end else begin
        check("idle_frame_done", frame_done, 0);
        if (exp_q.size() != 0) begin
          n_cmp++;
          n_err++;
          $display("FAIL missing_write: we low with %0d expected at %0t", exp_q.size(), $time);
          exp_q.delete();
        end
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send(input logic [15:0] re, input logic [15:0] im);
    bit ok;
    ok = 1'b0;
    s_valid = 1'b1;
    s_re = re;
    s_im = im;
    for (int i = 0; i < 64 && !ok; i++) begin
      @(negedge clk);
      ok = s_ready;
      tick();
    end
    if (!ok) begin
      n_cmp++;
      n_err++;
      $display("FAIL send_timeout: sample %0h never accepted", re);
    end
    s_valid = 1'b0;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err + 1);
    $fatal(1, "watchdog");
  end

  initial begin
    repeat (3) tick();
    rst = 1'b0;
    tick();

    s_valid = 1'b1;
    repeat (7) tick();
    s_valid = 1'b0;
    @(negedge clk);
    check("drop_idle_7", drop_cnt, 16'd7);
    check("no_write_idle", we, 0);
    tick();

    arm = 1'b1;
    fft_busy = 1'b1;
    repeat (4) tick();
    @(negedge clk);
    check("arm_while_busy_state", state_dbg, 2'd0);
    check("arm_while_busy_busy", busy, 0);
    tick();
    fft_busy = 1'b0;
    tick();

    // Frame A with a 5-cycle engine stall after sample 100; arm stays high into frame B.
    for (int k = 0; k <= 100; k++) send(16'(k), ~16'(k));
    fft_busy = 1'b1;
    s_valid = 1'b1;
    s_re = 16'd101;
    s_im = ~16'd101;
    repeat (5) tick();
    fft_busy = 1'b0;
    check("drop_after_stall", drop_cnt, 16'd12);
    for (int k = 101; k < DEPTH; k++) send(16'(k), ~16'(k));

    for (int k = 0; k < 500; k++) send(16'(k), ~16'(k));
    rst = 1'b1;
    arm = 1'b0;
    @(negedge clk);
    check("rst_mid_frame_state", state_dbg, 2'd0);
    check("rst_mid_frame_we", we, 0);
    tick();
    tick();
    rst = 1'b0;
    tick();

    arm = 1'b1;
    tick();
    arm = 1'b0;
    for (int k = 0; k < DEPTH; k++) send(16'(k), ~16'(k));
    repeat (3) tick();
    check("frames_completed", frames_done, 2);
`ifdef FFT_LOADER_BITREV_EN
    check("addr_k1", addr_k1, 16'h0200);
    check("addr_k3", addr_k3, 16'h0300);
`else
    check("addr_k1", addr_k1, 16'h0001);
    check("addr_k3", addr_k3, 16'h0003);
`endif
    check("addr_k1023", addr_k1023, 16'h03FF);

    s_valid = 1'b1;
    repeat (65540) tick();
    s_valid = 1'b0;
    tick();
    check("drop_saturated", drop_cnt, 16'hFFFF);

    repeat (2) tick();
    check("queue_drained", exp_q.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
